// File: rtl/alu_share_arb_if.sv
// ALU operation encoding and the requester-side handshake bundle.
// The package sits here because the interface is the first user of ALUSel_e.
package singlecycle_pkg;
   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_SLTU = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9
   } ALUSel_e;
endpackage

// Per-requester request/response lanes, one bit or word per requester.
interface alu_share_arb_if #(parameter int NUM_REQ = 2);
   import singlecycle_pkg::*;

   logic    [NUM_REQ-1:0]       i_req_valid;
   logic    [NUM_REQ-1:0]       o_req_ready;
   logic    [NUM_REQ-1:0][31:0] i_req_op_a;
   logic    [NUM_REQ-1:0][31:0] i_req_op_b;
   ALUSel_e [NUM_REQ-1:0]       i_req_alu_op;
   logic    [NUM_REQ-1:0]       o_rsp_valid;
   logic    [NUM_REQ-1:0]       i_rsp_ready;
   logic    [NUM_REQ-1:0][31:0] o_rsp_data;

   // Requesters drive operations and consume results.
   modport master (
      output i_req_valid, i_req_op_a, i_req_op_b, i_req_alu_op, i_rsp_ready,
      input  o_req_ready, o_rsp_valid, o_rsp_data
   );

   // The arbiter accepts operations and returns results.
   modport slave (
      input  i_req_valid, i_req_op_a, i_req_op_b, i_req_alu_op, i_rsp_ready,
      output o_req_ready, o_rsp_valid, o_rsp_data
   );
endinterface

// File: rtl/alu_share_arb.sv
// One combinational ALU shared round-robin by NUM_REQ requesters.
// Path: grant -> issue register -> ALU -> per-requester response register
// (two-cycle latency, one op per cycle, one outstanding op per requester).

// Combinational 32-bit ALU; unknown selects yield zero.
module alu
   import singlecycle_pkg::*;
(
   input  logic [31:0] i_op_a,
   input  logic [31:0] i_op_b,
   input  ALUSel_e     i_alu_sel,
   output logic [31:0] o_result
);
   // Decode the operation; shift amounts use only the low five bits of B.
   always_comb begin
      o_result = '0;
      case (i_alu_sel)
         ALU_ADD:  o_result = i_op_a + i_op_b;
         ALU_SUB:  o_result = i_op_a - i_op_b;
         ALU_SLL:  o_result = i_op_a << i_op_b[4:0];
         ALU_SLT:  o_result = {31'd0, $signed(i_op_a) < $signed(i_op_b)};
         ALU_SLTU: o_result = {31'd0, i_op_a < i_op_b};
         ALU_XOR:  o_result = i_op_a ^ i_op_b;
         ALU_SRL:  o_result = i_op_a >> i_op_b[4:0];
         ALU_SRA:  o_result = $unsigned($signed(i_op_a) >>> i_op_b[4:0]);
         ALU_OR:   o_result = i_op_a | i_op_b;
         ALU_AND:  o_result = i_op_a & i_op_b;
         default:  o_result = '0;
      endcase
   end
endmodule

module alu_share_arb
   import singlecycle_pkg::*;
#(
   parameter int NUM_REQ = 2
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_flush,
   alu_share_arb_if.slave  bus,
   output logic            o_busy
);
   localparam int PTR_W = $clog2(NUM_REQ);

   // Requester index 'off' positions after 'base', wrapping at NUM_REQ.
   function automatic logic [PTR_W-1:0] rr_idx(input logic [PTR_W-1:0] base, input int off);
      return PTR_W'((int'(base) + off) % NUM_REQ);
   endfunction

   logic [PTR_W-1:0]         ptr_q, ptr_d;
   logic                     iss_vld_q, iss_vld_d;
   logic [31:0]              iss_a_q, iss_a_d;
   logic [31:0]              iss_b_q, iss_b_d;
   ALUSel_e                  iss_op_q, iss_op_d;
   logic [PTR_W-1:0]         iss_own_q, iss_own_d;
   logic [NUM_REQ-1:0]       rsp_vld_q, rsp_vld_d;
   logic [NUM_REQ-1:0][31:0] rsp_data_q, rsp_data_d;

   logic [NUM_REQ-1:0]       elig;
   logic [NUM_REQ-1:0]       gnt;
   logic                     gnt_any;
   logic [PTR_W-1:0]         gnt_idx;
   logic [31:0]              alu_res;

   alu u_alu (
      .i_op_a    (iss_a_q),
      .i_op_b    (iss_b_q),
      .i_alu_sel (iss_op_q),
      .o_result  (alu_res)
   );

   // A requester may be granted once its previous op has left the issue
   // register and its response slot is empty or being popped this cycle.
   always_comb begin
      elig = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         elig[k] = !(iss_vld_q && (iss_own_q == PTR_W'(k)))
                   && (!rsp_vld_q[k] || bus.i_rsp_ready[k]);
      end
   end

   // Round-robin scan starting at ptr; flush and reset suppress all grants.
   always_comb begin
      gnt     = '0;
      gnt_any = 1'b0;
      gnt_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!gnt_any && bus.i_req_valid[rr_idx(ptr_q, i)] && elig[rr_idx(ptr_q, i)]) begin
            gnt_any                 = 1'b1;
            gnt_idx                 = rr_idx(ptr_q, i);
            gnt[rr_idx(ptr_q, i)]   = 1'b1;
         end
      end
      if (i_flush || i_rst) begin
         gnt     = '0;
         gnt_any = 1'b0;
      end
   end

   // Issue register loads on a grant and otherwise drains in one cycle,
   // so it never stalls; the pointer moves just past the winner.
   always_comb begin
      iss_vld_d = gnt_any;
      iss_a_d   = iss_a_q;
      iss_b_d   = iss_b_q;
      iss_op_d  = iss_op_q;
      iss_own_d = iss_own_q;
      ptr_d     = ptr_q;
      if (gnt_any) begin
         iss_a_d   = bus.i_req_op_a[gnt_idx];
         iss_b_d   = bus.i_req_op_b[gnt_idx];
         iss_op_d  = bus.i_req_alu_op[gnt_idx];
         iss_own_d = gnt_idx;
         ptr_d     = rr_idx(gnt_idx, 1);
      end
   end

   // Response slots: pop on rsp_ready, a draining result overrides the pop,
   // and flush discards everything including the draining result.
   always_comb begin
      rsp_vld_d  = rsp_vld_q & ~bus.i_rsp_ready;
      rsp_data_d = rsp_data_q;
      if (iss_vld_q && !i_flush) begin
         rsp_vld_d[iss_own_q]  = 1'b1;
         rsp_data_d[iss_own_q] = alu_res;
      end
      if (i_flush) begin
         rsp_vld_d = '0;
      end
   end

   // State registers.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         ptr_q      <= '0;
         iss_vld_q  <= 1'b0;
         iss_a_q    <= '0;
         iss_b_q    <= '0;
         iss_op_q   <= ALU_ADD;
         iss_own_q  <= '0;
         rsp_vld_q  <= '0;
         rsp_data_q <= '0;
      end else begin
         ptr_q      <= ptr_d;
         iss_vld_q  <= iss_vld_d;
         iss_a_q    <= iss_a_d;
         iss_b_q    <= iss_b_d;
         iss_op_q   <= iss_op_d;
         iss_own_q  <= iss_own_d;
         rsp_vld_q  <= rsp_vld_d;
         rsp_data_q <= rsp_data_d;
      end
   end

   assign bus.o_req_ready = gnt;
   assign bus.o_rsp_valid = rsp_vld_q;
   assign bus.o_rsp_data  = rsp_data_q;
   assign o_busy          = iss_vld_q | (|rsp_vld_q);
endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: directed scenarios plus a randomized run checked
// against a transaction-level model (per-requester op, result, arrival cycle).
module tb_alu_share_arb;
   import singlecycle_pkg::*;
   localparam int NR = 2;

   logic clk = 1'b0;
   logic rst;
   logic flush;
   logic busy;
   int   n_cmp = 0;
   int   n_fail = 0;

   alu_share_arb_if #(.NUM_REQ(NR)) bus ();

   alu_share_arb #(.NUM_REQ(NR)) dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_flush (flush),
      .bus     (bus),
      .o_busy  (busy)
   );

   always #5 clk = ~clk;

   // Reference arithmetic straight from the operation definitions.
   function automatic logic [31:0] alu_ref(input int op, input logic [31:0] a, input logic [31:0] b);
      int sh;
      sh = int'(b[4:0]);
      case (op)
         0: return a + b;
         1: return a - b;
         2: return a << sh;
         3: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4: return (a < b) ? 32'd1 : 32'd0;
         5: return a ^ b;
         6: return a >> sh;
         7: return $unsigned($signed(a) >>> sh);
         8: return a | b;
         9: return a & b;
         default: return 32'd0;
      endcase
   endfunction

   task automatic idle();
      bus.i_req_valid  = '0;
      bus.i_req_op_a   = '0;
      bus.i_req_op_b   = '0;
      bus.i_req_alu_op = {NR{ALU_ADD}};
      bus.i_rsp_ready  = '1;
      flush            = 1'b0;
   endtask

   // Advance to the middle of the next cycle (inputs driven after negedge).
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic req(input int k, input ALUSel_e op, input logic [31:0] a, input logic [31:0] b);
      bus.i_req_valid[k]  = 1'b1;
      bus.i_req_alu_op[k] = op;
      bus.i_req_op_a[k]   = a;
      bus.i_req_op_b[k]   = b;
   endtask

   task automatic do_reset();
      @(negedge clk);
      idle();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      idle();
      rst = 1'b1;
      bus.i_req_valid = '1;
      #1;
      n_cmp++; if (bus.o_req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_ready got=%b exp=00", bus.o_req_ready); end
      n_cmp++; if (bus.o_rsp_valid !== 2'b00) begin n_fail++; $display("FAIL reset_rsp_valid got=%b exp=00", bus.o_rsp_valid); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
      n_cmp++; if (bus.o_rsp_data !== 64'd0) begin n_fail++; $display("FAIL reset_data got=%h exp=0", bus.o_rsp_data); end
      tick();
      idle();
      rst = 1'b0;
   endtask

   task automatic test_single_op();
      do_reset();
      req(0, ALU_ADD, 32'd5, 32'd7);                      // cycle 1
      #1;
      n_cmp++; if (bus.o_req_ready !== 2'b01) begin n_fail++; $display("FAIL single_ready got=%b exp=01", bus.o_req_ready); end
      tick(); idle();                                     // cycle 2
      #1;
      n_cmp++; if (bus.o_rsp_valid !== 2'b00 || busy !== 1'b1) begin n_fail++; $display("FAIL single_c2 vld=%b busy=%b exp=00/1", bus.o_rsp_valid, busy); end
      tick();                                             // cycle 3
      #1;
      n_cmp++; if (bus.o_rsp_valid !== 2'b01) begin n_fail++; $display("FAIL single_c3_valid got=%b exp=01", bus.o_rsp_valid); end
      n_cmp++; if (bus.o_rsp_data[0] !== 32'd12) begin n_fail++; $display("FAIL single_data got=%0d exp=12", bus.o_rsp_data[0]); end
      tick();                                             // cycle 4
      #1;
      n_cmp++; if (bus.o_rsp_valid !== 2'b00 || busy !== 1'b0) begin n_fail++; $display("FAIL single_c4 vld=%b busy=%b exp=00/0", bus.o_rsp_valid, busy); end
   endtask

   task automatic test_contention();
      do_reset();
      req(0, ALU_SUB, 32'd3, 32'd5);
      req(1, ALU_SRA, 32'h8000_0000, 32'd4);
      #1;
      n_cmp++; if (bus.o_req_ready !== 2'b01) begin n_fail++; $display("FAIL cont_c1_ready got=%b exp=01", bus.o_req_ready); end
      tick(); bus.i_req_valid[0] = 1'b0;
      #1;
      n_cmp++; if (bus.o_req_ready !== 2'b10) begin n_fail++; $display("FAIL cont_c2_ready got=%b exp=10", bus.o_req_ready); end
      tick(); idle();
      #1;
      n_cmp++; if (bus.o_rsp_valid !== 2'b01 || bus.o_rsp_data[0] !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL cont_c3 vld=%b d0=%h exp=01/fffffffe", bus.o_rsp_valid, bus.o_rsp_data[0]); end
      tick();
      #1;
      n_cmp++; if (bus.o_rsp_valid !== 2'b10 || bus.o_rsp_data[1] !== 32'hF800_0000) begin n_fail++; $display("FAIL cont_c4 vld=%b d1=%h exp=10/f8000000", bus.o_rsp_valid, bus.o_rsp_data[1]); end
   endtask

   task automatic test_fairness();
      logic [1:0] exp;
      do_reset();
      req(0, ALU_ADD, 32'd1, 32'd1);
      req(1, ALU_ADD, 32'd2, 32'd2);
      for (int i = 0; i < 12; i++) begin
         #1;
         exp = (i % 2 == 0) ? 2'b01 : 2'b10;
         n_cmp++; if (bus.o_req_ready !== exp) begin n_fail++; $display("FAIL fair_grant%0d got=%b exp=%b", i, bus.o_req_ready, exp); end
         tick();
      end
      idle();
      tick(); tick();
   endtask

   task automatic test_backpressure();
      do_reset();
      bus.i_rsp_ready = 2'b10;
      req(0, ALU_SLT, 32'hFFFF_FFFF, 32'd1);              // c1
      #1;
      n_cmp++; if (bus.o_req_ready !== 2'b01) begin n_fail++; $display("FAIL bp_c1_ready got=%b exp=01", bus.o_req_ready); end
      tick();                                             // c2
      req(0, ALU_ADD, 32'd1, 32'd1);
      req(1, ALU_SLTU, 32'hFFFF_FFFF, 32'd1);
      #1;
      n_cmp++; if (bus.o_req_ready !== 2'b10) begin n_fail++; $display("FAIL bp_c2_ready got=%b exp=10", bus.o_req_ready); end
      tick(); bus.i_req_valid[1] = 1'b0;                  // c3
      #1;
      n_cmp++; if (bus.o_rsp_valid !== 2'b01 || bus.o_rsp_data[0] !== 32'd1 || bus.o_req_ready !== 2'b00) begin n_fail++; $display("FAIL bp_c3 vld=%b d0=%h rdy=%b exp=01/1/00", bus.o_rsp_valid, bus.o_rsp_data[0], bus.o_req_ready); end
      tick();                                             // c4
      #1;
      n_cmp++; if (bus.o_rsp_valid !== 2'b11 || bus.o_rsp_data[1] !== 32'd0 || bus.o_req_ready !== 2'b00) begin n_fail++; $display("FAIL bp_c4 vld=%b d1=%h rdy=%b exp=11/0/00", bus.o_rsp_valid, bus.o_rsp_data[1], bus.o_req_ready); end
      tick();                                             // c5
      #1;
      n_cmp++; if (bus.o_rsp_valid !== 2'b01 || bus.o_rsp_data[0] !== 32'd1 || bus.o_req_ready !== 2'b00) begin n_fail++; $display("FAIL bp_c5 vld=%b d0=%h rdy=%b exp=01/1/00", bus.o_rsp_valid, bus.o_rsp_data[0], bus.o_req_ready); end
      tick(); bus.i_rsp_ready = 2'b11;                    // c6
      #1;
      n_cmp++; if (bus.o_req_ready !== 2'b01) begin n_fail++; $display("FAIL bp_c6_ready got=%b exp=01", bus.o_req_ready); end
      tick(); bus.i_req_valid = '0;                       // c7
      #1;
      n_cmp++; if (bus.o_rsp_valid !== 2'b00) begin n_fail++; $display("FAIL bp_c7_valid got=%b exp=00", bus.o_rsp_valid); end
      tick();                                             // c8
      #1;
      n_cmp++; if (bus.o_rsp_valid !== 2'b01 || bus.o_rsp_data[0] !== 32'd2) begin n_fail++; $display("FAIL bp_c8 vld=%b d0=%h exp=01/2", bus.o_rsp_valid, bus.o_rsp_data[0]); end
   endtask

   task automatic test_flush();
      do_reset();
      req(0, ALU_ADD, 32'd10, 32'd20);                    // c1
      #1;
      n_cmp++; if (bus.o_req_ready !== 2'b01) begin n_fail++; $display("FAIL fl_c1_ready got=%b exp=01", bus.o_req_ready); end
      tick(); idle();                                     // c2: flush
      flush = 1'b1;
      req(1, ALU_ADD, 32'd1, 32'd2);
      #1;
      n_cmp++; if (bus.o_req_ready !== 2'b00) begin n_fail++; $display("FAIL fl_c2_ready got=%b exp=00", bus.o_req_ready); end
      tick(); flush = 1'b0;                               // c3
      #1;
      n_cmp++; if (bus.o_rsp_valid !== 2'b00 || bus.o_req_ready !== 2'b10) begin n_fail++; $display("FAIL fl_c3 vld=%b rdy=%b exp=00/10", bus.o_rsp_valid, bus.o_req_ready); end
      tick(); idle();                                     // c4
      #1;
      n_cmp++; if (bus.o_rsp_valid !== 2'b00 || busy !== 1'b1) begin n_fail++; $display("FAIL fl_c4 vld=%b busy=%b exp=00/1", bus.o_rsp_valid, busy); end
      tick();                                             // c5
      #1;
      n_cmp++; if (bus.o_rsp_valid !== 2'b10 || bus.o_rsp_data[1] !== 32'd3) begin n_fail++; $display("FAIL fl_c5 vld=%b d1=%h exp=10/3", bus.o_rsp_valid, bus.o_rsp_data[1]); end
   endtask

   task automatic test_async_reset();
      do_reset();
      bus.i_rsp_ready = 2'b00;
      req(1, ALU_ADD, 32'd100, 32'd1);                    // c1
      #1;
      n_cmp++; if (bus.o_req_ready !== 2'b10) begin n_fail++; $display("FAIL ar_c1_ready got=%b exp=10", bus.o_req_ready); end
      tick(); bus.i_req_valid = '0;                       // c2
      req(0, ALU_SUB, 32'd9, 32'd4);
      #1;
      n_cmp++; if (bus.o_req_ready !== 2'b01) begin n_fail++; $display("FAIL ar_c2_ready got=%b exp=01", bus.o_req_ready); end
      tick(); bus.i_req_valid = '0;                       // c3
      #1;
      n_cmp++; if (bus.o_rsp_valid !== 2'b10 || busy !== 1'b1 || bus.o_rsp_data[1] !== 32'd101) begin n_fail++; $display("FAIL ar_c3 vld=%b busy=%b d1=%h exp=10/1/65", bus.o_rsp_valid, busy, bus.o_rsp_data[1]); end
      bus.i_req_valid = '1;
      #2 rst = 1'b1;
      #1;
      n_cmp++; if (bus.o_rsp_valid !== 2'b00 || busy !== 1'b0 || bus.o_req_ready !== 2'b00) begin n_fail++; $display("FAIL ar_mid vld=%b busy=%b rdy=%b exp=00/0/00", bus.o_rsp_valid, busy, bus.o_req_ready); end
      tick(); rst = 1'b0;
      bus.i_rsp_ready = 2'b11;
      #1;
      n_cmp++; if (bus.o_req_ready !== 2'b01) begin n_fail++; $display("FAIL ar_first_grant got=%b exp=01", bus.o_req_ready); end
      tick(); idle(); tick(); tick();
   endtask

   // Randomized traffic against a transaction model: each requester owns at
   // most one op, whose result becomes visible two cycles after its grant.
   task automatic test_random();
      bit          have_op [NR];
      logic [31:0] res     [NR];
      int          arrive  [NR];
      bit          granted [NR];
      bit          vis     [NR];
      bit          elig    [NR];
      logic [1:0]  exp_rdy, exp_vld;
      int          ptr, cyc, g, k;
      do_reset();
      ptr = 0; cyc = 0;
      for (int i = 0; i < NR; i++) begin have_op[i] = 0; granted[i] = 0; res[i] = '0; arrive[i] = 0; end
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < NR; i++) begin
            if (bus.i_req_valid[i] && !granted[i]) begin
               if ($urandom_range(0, 99) < 15) bus.i_req_valid[i] = 1'b0;
            end else begin
               bus.i_req_valid[i]  = 1'($urandom_range(0, 1));
               bus.i_req_alu_op[i] = ALUSel_e'(4'($urandom_range(0, 11)));
               bus.i_req_op_a[i]   = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 ^ 32'($urandom_range(0, 7)) : $urandom;
               bus.i_req_op_b[i]   = $urandom;
            end
            bus.i_rsp_ready[i] = ($urandom_range(0, 99) < 60);
         end
         flush = ($urandom_range(0, 99) < 5);
         #1;
         exp_rdy = '0; exp_vld = '0; g = -1;
         for (int i = 0; i < NR; i++) begin
            vis[i]     = have_op[i] && (cyc >= arrive[i]);
            elig[i]    = !have_op[i] || (vis[i] && bus.i_rsp_ready[i]);
            exp_vld[i] = vis[i];
         end
         if (!flush) begin
            for (int i = 0; i < NR; i++) begin
               k = (ptr + i) % NR;
               if (g < 0 && bus.i_req_valid[k] && elig[k]) g = k;
            end
         end
         if (g >= 0) exp_rdy[g] = 1'b1;
         n_cmp++; if (bus.o_req_ready !== exp_rdy) begin n_fail++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", c, bus.o_req_ready, exp_rdy); end
         n_cmp++; if (bus.o_rsp_valid !== exp_vld) begin n_fail++; $display("FAIL rnd_rsp_valid cyc=%0d got=%b exp=%b", c, bus.o_rsp_valid, exp_vld); end
         n_cmp++; if (busy !== (have_op[0] | have_op[1])) begin n_fail++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", c, busy, have_op[0] | have_op[1]); end
         for (int i = 0; i < NR; i++) begin
            if (vis[i]) begin
               n_cmp++; if (bus.o_rsp_data[i] !== res[i]) begin n_fail++; $display("FAIL rnd_data%0d cyc=%0d got=%h exp=%h", i, c, bus.o_rsp_data[i], res[i]); end
            end
         end
         @(posedge clk);
         for (int i = 0; i < NR; i++) begin
            if (vis[i] && bus.i_rsp_ready[i]) have_op[i] = 0;
            if (flush) have_op[i] = 0;
            granted[i] = (g == i);
         end
         if (g >= 0) begin
            have_op[g] = 1;
            res[g]     = alu_ref(int'(bus.i_req_alu_op[g]), bus.i_req_op_a[g], bus.i_req_op_b[g]);
            arrive[g]  = cyc + 2;
            ptr        = (g + 1) % NR;
         end
         cyc++;
         @(negedge clk);
      end
      idle();
   endtask

   initial begin
      rst = 1'b1;
      idle();
      test_reset();
      test_single_op();
      test_contention();
      test_fairness();
      test_backpressure();
      test_flush();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
